lisa_uart_sync_tx: RTL and testbench

//  Buffered 8N1 UART transmitter for the far end of a LISA autobaud link. It

---
 rtl/lisa_uart_sync_tx_pkg.sv | 19 +
 rtl/lisa_uart_sync_tx_if.sv | 27 ++
 rtl/lisa_uart_sync_tx_fifo.sv | 56 +++++
 rtl/lisa_uart_sync_tx.sv | 163 ++++++++++++++++
 tb/tb_lisa_uart_sync_tx.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/lisa_uart_sync_tx_pkg.sv
// Shared definitions for the LISA 8N1 transmitter family.
//   tx_state_e      : frame sequencer states (IDLE/START/DATA/STOP)
//   FRAME_DATA_BITS : data bits per frame
//   START_LVL       : line level of the start bit
//   IDLE_LVL        : line level when idle and during stop bits
package lisa_uart_sync_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  localparam int   FRAME_DATA_BITS = 8;
  localparam logic START_LVL       = 1'b0;
  localparam logic IDLE_LVL        = 1'b1;

endpackage

// File: rtl/lisa_uart_sync_tx_if.sv
// Host-side bus of the LISA sync transmitter.
//   master (host) drives : brg_wr, brg_d, tx_d, tx_wr, sync_req
//   slave  (tx)   drives : txd, tx_full, tx_empty, sync_busy, tx_ovf
interface lisa_uart_sync_tx_if;

  logic       brg_wr;
  logic [7:0] brg_d;
  logic [7:0] tx_d;
  logic       tx_wr;
  logic       sync_req;
  logic       txd;
  logic       tx_full;
  logic       tx_empty;
  logic       sync_busy;
  logic       tx_ovf;

  modport master (
    output brg_wr, brg_d, tx_d, tx_wr, sync_req,
    input  txd, tx_full, tx_empty, sync_busy, tx_ovf
  );

  modport slave (
    input  brg_wr, brg_d, tx_d, tx_wr, sync_req,
    output txd, tx_full, tx_empty, sync_busy, tx_ovf
  );

endinterface

// File: rtl/lisa_uart_sync_tx_fifo.sv
// Small synchronous FIFO holding bytes waiting to be serialised.
//   clk, rst  : clock, asynchronous active-high reset (clears pointers)
//   push_i    : write din_i (ignored when full)
//   pop_i     : drop the head entry (ignored when empty)
//   din_i     : write data
//   dout_o    : head entry, valid whenever empty_o is low
//   full_o    : no free entry
//   empty_o   : no stored entry
module lisa_uart_sync_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  // One extra pointer bit tells a full buffer from an empty one.
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             push_ok;
  logic             pop_ok;

  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q[AW-1:0]] <= din_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/lisa_uart_sync_tx.sv
// Buffered 8N1 transmitter for the far end of a LISA autobaud link. Sends a
// SYNC_COUNT x SYNC_CHAR training preamble on request, then streams queued
// bytes, with its own bit-rate divider.
//   clk   : system clock
//   rst   : asynchronous active-high reset (line forced idle at once)
//   tx_if : host bus (brg_wr/brg_d, tx_d/tx_wr, sync_req in;
//           txd, tx_full, tx_empty, sync_busy, tx_ovf out)
module lisa_uart_sync_tx
  import lisa_uart_sync_tx_pkg::*;
#(
  parameter int         FIFO_DEPTH  = 4,
  parameter logic [7:0] SYNC_CHAR   = 8'h55,
  parameter int         SYNC_COUNT  = 2,
  parameter logic [7:0] DEFAULT_DIV = 8'd103,
  parameter int         STOP_BITS   = 1
) (
  input  logic               clk,
  input  logic               rst,
  lisa_uart_sync_tx_if.slave tx_if
);

  logic [7:0] div_q;
  logic [7:0] cnt_q;
  logic       tick;

  tx_state_e  state_q;
  logic [7:0] shift_q;
  logic [2:0] bit_idx_q;
  logic [1:0] stop_cnt_q;
  logic       txd_q;
  logic [3:0] sync_cnt_q;
  logic       sync_frame_q;   // the frame on the line is a preamble byte
  logic       sync_busy_q;
  logic       tx_ovf_q;

  logic       fifo_push;
  logic       fifo_pop;
  logic [7:0] fifo_dout;
  logic       fifo_full;
  logic       fifo_empty;
  logic       last_stop;
  logic       boundary;
  logic       sync_accept;

  // Bit-rate divider: one tick every div+1 cycles; a divisor write restarts
  // the current period from the new value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q <= DEFAULT_DIV;
      cnt_q <= DEFAULT_DIV;
    end else if (tx_if.brg_wr) begin
      div_q <= tx_if.brg_d;
      cnt_q <= tx_if.brg_d;
    end else if (tick) begin
      cnt_q <= div_q;
    end else begin
      cnt_q <= cnt_q - 8'd1;
    end
  end

  assign tick = (cnt_q == 8'd0);

  lisa_uart_sync_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .din_i   (tx_if.tx_d),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // A write at full is dropped even if a pop frees a slot in the same cycle.
  assign fifo_push = tx_if.tx_wr && !fifo_full;

  // Frame boundary: an idle tick, or the tick that ends the last stop bit.
  // Starting the next frame here keeps frames back-to-back.
  assign last_stop = (state_q == ST_STOP) && (stop_cnt_q == 2'(STOP_BITS - 1));
  assign boundary  = tick && ((state_q == ST_IDLE) || last_stop);

  // Preamble wins every boundary, so FIFO data waits while sync_cnt != 0.
  assign fifo_pop  = boundary && (sync_cnt_q == 4'd0) && !fifo_empty;

  // A new preamble is only armed once the previous one has fully drained.
  assign sync_accept = tx_if.sync_req && (sync_cnt_q == 4'd0) && !sync_frame_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      shift_q      <= '0;
      bit_idx_q    <= '0;
      stop_cnt_q   <= '0;
      txd_q        <= IDLE_LVL;
      sync_cnt_q   <= '0;
      sync_frame_q <= 1'b0;
      sync_busy_q  <= 1'b0;
      tx_ovf_q     <= 1'b0;
    end else begin
      tx_ovf_q <= tx_if.tx_wr && fifo_full;

      if (boundary) begin
        if (sync_cnt_q != 4'd0) begin
          shift_q      <= SYNC_CHAR;
          sync_cnt_q   <= sync_cnt_q - 4'd1;
          sync_frame_q <= 1'b1;
          state_q      <= ST_START;
          txd_q        <= START_LVL;
        end else if (!fifo_empty) begin
          shift_q      <= fifo_dout;
          sync_frame_q <= 1'b0;
          state_q      <= ST_START;
          txd_q        <= START_LVL;
        end else begin
          sync_frame_q <= 1'b0;
          state_q      <= ST_IDLE;
          txd_q        <= IDLE_LVL;
        end
      end else if (tick) begin
        case (state_q)
          ST_START: begin
            txd_q     <= shift_q[0];
            shift_q   <= shift_q >> 1;
            bit_idx_q <= '0;
            state_q   <= ST_DATA;
          end
          ST_DATA: begin
            if (bit_idx_q == 3'(FRAME_DATA_BITS - 1)) begin
              txd_q      <= IDLE_LVL;
              stop_cnt_q <= '0;
              state_q    <= ST_STOP;
            end else begin
              txd_q     <= shift_q[0];
              shift_q   <= shift_q >> 1;
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end
          ST_STOP: stop_cnt_q <= stop_cnt_q + 2'd1;
          default: ;
        endcase
      end

      // sync_cnt is only loaded at zero and only decremented when non-zero,
      // so the two updates never collide.
      if (sync_accept) begin
        sync_cnt_q  <= 4'(SYNC_COUNT);
        sync_busy_q <= 1'b1;
      end else if (boundary && (sync_cnt_q == 4'd0)) begin
        sync_busy_q <= 1'b0;
      end
    end
  end

  assign tx_if.txd       = txd_q;
  assign tx_if.tx_full   = fifo_full;
  assign tx_if.tx_empty  = (state_q == ST_IDLE) && fifo_empty && (sync_cnt_q == 4'd0);
  assign tx_if.sync_busy = sync_busy_q;
  assign tx_if.tx_ovf    = tx_ovf_q;

endmodule

// File: tb/tb_lisa_uart_sync_tx.sv
// Bench for lisa_uart_sync_tx: directed scenarios plus randomized bursts.
// Expected bytes come from a queue built from the transmitter's rules
// (preamble first, FIFO keeps the first FIFO_DEPTH bytes of a burst); each
// frame on txd is compared cycle by cycle to the ideal 8N1 waveform.
module tb_lisa_uart_sync_tx;

  localparam int         FIFO_DEPTH = 4;
  localparam int         SYNC_COUNT = 2;
  localparam logic [7:0] SYNC_CHAR  = 8'h55;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   cur_p;
  logic [7:0] burst_b [6];

  lisa_uart_sync_tx_if bus ();

  lisa_uart_sync_tx dut (
    .clk   (clk),
    .rst   (rst),
    .tx_if (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic set_brg(input logic [7:0] d);
    bus.brg_wr = 1'b1;
    bus.brg_d  = d;
    @(negedge clk);
    bus.brg_wr = 1'b0;
    cur_p = int'(d) + 1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    bus.tx_wr = 1'b1;
    bus.tx_d  = b;
    @(negedge clk);
    bus.tx_wr = 1'b0;
  endtask

  // Waits (bounded) for a start bit, then checks 10*P samples against the
  // ideal frame. Ends on the first sample after the stop bit.
  task automatic recv_frame(input logic [7:0] exp, input int p, input int max_wait,
                            input bit need_b2b, input string tag, output logic busy_last);
    int         waited;
    logic [9:0] pat;
    bit         shape_ok;
    logic [7:0] got;
    pat       = {1'b1, exp, 1'b0};
    waited    = 0;
    shape_ok  = 1'b1;
    got       = '0;
    busy_last = 1'b0;
    while (bus.txd !== 1'b0 && waited < max_wait) begin
      @(negedge clk);
      waited++;
    end
    chk({tag, "_start"}, bus.txd, 1'b0);
    if (need_b2b) chk({tag, "_gap"}, waited, 0);
    for (int k = 0; k < 10 * p; k++) begin
      if (bus.txd !== pat[k / p]) shape_ok = 1'b0;
      if ((k % p) == (p / 2) && (k / p) >= 1 && (k / p) <= 8) got[(k / p) - 1] = bus.txd;
      if (k == 10 * p - 1) busy_last = bus.sync_busy;
      @(negedge clk);
    end
    chk({tag, "_byte"}, got, exp);
    chk({tag, "_shape"}, shape_ok, 1'b1);
    $display("frame %s: expected %02h decoded %02h wait %0d clk/bit %0d shape_ok %0d",
             tag, exp, got, waited, p, shape_ok);
  endtask

  task automatic expect_idle(input int ncyc, input string tag);
    bit seen_low;
    seen_low = 1'b0;
    for (int k = 0; k < ncyc; k++) begin
      if (bus.txd !== 1'b1) seen_low = 1'b1;
      @(negedge clk);
    end
    chk(tag, seen_low, 1'b0);
  endtask

  // Set divisor, optionally request a preamble, push n bytes of burst_b on
  // consecutive cycles (all before the first tick), then check the output.
  task automatic run_burst(input logic [7:0] div, input bit do_sync, input int n, input string tag);
    logic [7:0] exp_q [$];
    logic       bl;
    int         p;
    chk({tag, "_pre_empty"}, bus.tx_empty, 1'b1);
    set_brg(div);
    p = cur_p;
    for (int i = 0; i < n; i++) begin
      bus.tx_wr    = 1'b1;
      bus.tx_d     = burst_b[i];
      bus.sync_req = (i == 0) && do_sync;
      @(negedge clk);
      bus.tx_wr    = 1'b0;
      bus.sync_req = 1'b0;
      chk($sformatf("%s_ovf%0d", tag, i), bus.tx_ovf, (i >= FIFO_DEPTH));
      if (i == 0 && do_sync) chk({tag, "_busy_set"}, bus.sync_busy, 1'b1);
    end
    chk({tag, "_full"}, bus.tx_full, (n >= FIFO_DEPTH));
    if (do_sync) for (int i = 0; i < SYNC_COUNT; i++) exp_q.push_back(SYNC_CHAR);
    for (int i = 0; i < n && i < FIFO_DEPTH; i++) exp_q.push_back(burst_b[i]);
    $display("burst %s: div %0d sync %0d pushed %0d expect %0d frames",
             tag, div, do_sync, n, exp_q.size());
    for (int j = 0; j < exp_q.size(); j++) begin
      recv_frame(exp_q[j], p, (j == 0) ? 2 * p + 4 : 0, (j > 0),
                 $sformatf("%s_f%0d", tag, j), bl);
      if (do_sync && j == SYNC_COUNT - 1) begin
        chk({tag, "_busy_last_stop"}, bl, 1'b1);
        chk({tag, "_busy_clear"}, bus.sync_busy, 1'b0);
      end
    end
    chk({tag, "_empty_end"}, bus.tx_empty, 1'b1);
  endtask

  initial begin
    logic bl;
    int   waited;
    checks       = 0;
    failures     = 0;
    cur_p        = 104;
    rst          = 1'b1;
    bus.brg_wr   = 1'b0;
    bus.brg_d    = '0;
    bus.tx_d     = '0;
    bus.tx_wr    = 1'b0;
    bus.sync_req = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_txd", bus.txd, 1'b1);
    chk("rst_full", bus.tx_full, 1'b0);
    chk("rst_empty", bus.tx_empty, 1'b1);
    chk("rst_busy", bus.sync_busy, 1'b0);
    chk("rst_ovf", bus.tx_ovf, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // Single byte at 4 clk/bit.
    burst_b[0] = 8'hA5;
    run_burst(8'd3, 1'b0, 1, "t1");

    // Preamble request with a data byte queued behind it.
    burst_b[0] = 8'h0D;
    run_burst(8'd3, 1'b1, 1, "t3");

    // Overflow: five pushes into a four-entry FIFO.
    for (int i = 0; i < 5; i++) burst_b[i] = 8'($urandom);
    run_burst(8'd9, 1'b0, 5, "t2");

    // Repeated sync_req gives exactly SYNC_COUNT preamble bytes.
    chk("t5_pre_empty", bus.tx_empty, 1'b1);
    set_brg(8'd5);
    bus.sync_req = 1'b1;
    repeat (3) @(negedge clk);
    bus.sync_req = 1'b0;
    chk("t5_busy", bus.sync_busy, 1'b1);
    for (int j = 0; j < SYNC_COUNT; j++)
      recv_frame(SYNC_CHAR, cur_p, 2 * cur_p + 4, (j > 0), $sformatf("t5_f%0d", j), bl);
    expect_idle(3 * cur_p, "t5_no_extra");

    // Randomized bursts.
    for (int it = 0; it < 10; it++) begin
      logic [7:0] d;
      bit         s;
      int         n;
      d = 8'($urandom_range(7, 15));
      s = 1'($urandom_range(0, 1));
      n = $urandom_range(1, 6);
      for (int i = 0; i < 6; i++) burst_b[i] = 8'($urandom);
      run_burst(d, s, n, $sformatf("rnd%0d", it));
    end

    // Reset in the middle of a frame.
    set_brg(8'd7);
    push_byte(8'hF7);
    push_byte(8'hC3);
    waited = 0;
    while (bus.txd !== 1'b0 && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    chk("t4_start", bus.txd, 1'b0);
    repeat (4 * cur_p + cur_p / 2) @(negedge clk);
    chk("t4_bit3", bus.txd, 1'b0);
    #2 rst = 1'b1;
    #1 chk("t4_txd_async", bus.txd, 1'b1);
    @(negedge clk);
    chk("t4_empty", bus.tx_empty, 1'b1);
    chk("t4_full", bus.tx_full, 1'b0);
    chk("t4_busy", bus.sync_busy, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    push_byte(8'h3A);
    recv_frame(8'h3A, 104, 110, 1'b0, "t4_after_rst", bl);
    expect_idle(2 * 104, "t4_fifo_cleared");
    chk("t4_empty_end", bus.tx_empty, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
